fft_readout_sched: RTL and testbench
====================================

FFT_READOUT_SCHED -- requirements
Module: fft_readout_sched

Interface
REQ-001 Parameters: NCH, default 4, number of FFT channels; NPTS, default 1024, bins per channel; RD_LAT, default 2, FFT RAM read latency in cycles (1..3).
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 ch_ready  in  NCH  per-channel "FFT RAM holds a complete frame" level.
REQ-005 ch_q  in  28*NCH  per-channel RAM read data {real[13:0], imag[13:0]}; channel k occupies bits 28k+27..28k.
REQ-006 rd_addr_fft  out  10  read address broadcast to all channel RAMs.
REQ-007 ch_go  out  1  frame-release level to all channels.
REQ-008 out_valid / out_ready  out / in  1 / 1  output stream handshake.
REQ-009 out_data  out  28  selected bin word.
REQ-010 out_ch  out  clog2(NCH)  channel of out_data.
REQ-011 out_bin  out  10  bin index of out_data.
REQ-012 out_sop / out_eop  out  1 / 1  first word of ch0 / last word of last channel in a frame.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, READ, DRAIN, RELEASE; encoding is free.
REQ-015 IDLE -> READ when ch_ready is all ones; partial readiness keeps the FSM in IDLE indefinitely.
REQ-016 READ issues one RAM read per cycle when credit is available: rd_addr_fft = bin, channel order ch0 bins 0..LAST, then ch1 bins 0..LAST, and so on.
REQ-017 LAST = NPTS-1, or the value defined in REQ-031 when that feature is enabled.
REQ-018 Each issued read carries {ch, bin, sop, eop} through an RD_LAT-deep tag pipeline; at tag exit, ch_q[ch] is written with its tag into a 4-entry output FIFO.
REQ-019 Credit: a read issues only if FIFO occupancy plus reads in flight < 4, so the FIFO never overflows and no read result is dropped.
REQ-020 The FIFO head drives out_*; a word transfers on out_valid && out_ready.
REQ-021 While out_valid is high and out_ready is low, out_data/out_ch/out_bin/out_sop/out_eop hold stable.
REQ-022 With out_ready held high, the output sustains one word per cycle after an initial latency of RD_LAT+1 cycles from READ entry.
REQ-023 READ -> DRAIN in the cycle after the read (NCH-1, LAST) issues; DRAIN -> RELEASE when the FIFO is empty, no reads are in flight, and the eop word has transferred.
REQ-024 RELEASE drives ch_go=1 until ch_ready is all zeros, then goes to IDLE with ch_go=0. ch_go is held as a level because the channels synchronise it through 2 flip-flops.
REQ-025 ch_ready deasserting during READ or DRAIN is ignored; the frame completes.
REQ-026 Bin and channel counters wrap to 0 exactly at LAST and NCH-1 respectively; no other wrap occurs.
REQ-027 Simultaneous FIFO push and pop when full or empty are legal; occupancy stays unchanged.

Reset
REQ-028 Asynchronous assertion of rst_n forces: state=IDLE; rd_addr_fft=0; ch_go=0; out_valid=0; out_sop=0; out_eop=0; out_data=0; out_ch=0; out_bin=0; busy=0; FIFO empty; tag pipeline invalid; counters 0.
REQ-029 Reset asserted mid-frame discards the frame; after reset release the block waits in IDLE for all-ones ch_ready.
REQ-030 Deassertion is sampled synchronously; the first state change can occur no earlier than the second rising edge after release.

Configuration
REQ-031 With macro FFT_SCHED_HALF_SPECTRUM_EN defined, LAST = NPTS/2 (bins 0..512 for NPTS=1024, DC through Nyquist) and eop marks (NCH-1, NPTS/2).
REQ-032 Without FFT_SCHED_HALF_SPECTRUM_EN, LAST = NPTS-1 and all bins are read.

Verification
REQ-033 All ch_ready=1, out_ready=1, NCH=4, full spectrum -> exactly 4096 words in order ch0..3, bins 0..1023; sop on word 0; eop on word 4095; first out_valid RD_LAT+1 cycles after READ entry; no gaps.
REQ-034 ch_ready=4'b0111 held for 500 cycles, then 4'b1111 -> no reads and busy=0 during the 500 cycles; the frame starts on the cycle after all ones.
REQ-035 Random out_ready at 30% duty with RAM model q=(ch<<10)|bin -> every word equals its tag, no loss or duplication, outputs stable under stall, FIFO occupancy never exceeds 4.
REQ-036 Frame complete, ch_ready held high 3 cycles then dropped -> ch_go=1 for those cycles; ch_go=0 and state=IDLE on the cycle after ch_ready reaches 0.
REQ-037 rst_n pulsed low at ch1 bin 300 -> all outputs at reset values immediately; with ch_ready=1 after release, a fresh frame restarts at ch0 bin 0 with sop.
REQ-038 FFT_SCHED_HALF_SPECTRUM_EN defined, NPTS=1024 -> 4x513 = 2052 words; eop on (ch3, bin 512).

Source files
------------

// File: rtl/fft_readout_sched.sv
// fft_readout_sched: reads NCH FFT channel RAMs (channel-major, bin-minor) into a 4-deep credit FIFO stream.
// Build option: define FFT_SCHED_HALF_SPECTRUM_EN to read bins 0..NPTS/2 (DC through Nyquist) only.
module fft_readout_sched #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned NPTS   = 1024,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NCH-1:0]                           ch_ready,
  input  logic [28*NCH-1:0]                        ch_q,
  output logic [9:0]                               rd_addr_fft,
  output logic                                     ch_go,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [27:0]                              out_data,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch,
  output logic [9:0]                               out_bin,
  output logic                                     out_sop,
  output logic                                     out_eop,
  output logic                                     busy
);

  localparam int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned BW    = 10;
  localparam int unsigned DW    = 28;
  localparam int unsigned DEPTH = 4;
`ifdef FFT_SCHED_HALF_SPECTRUM_EN
  localparam int unsigned LAST  = NPTS / 2;
`else
  localparam int unsigned LAST  = NPTS - 1;
`endif

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [BW-1:0]  bin;
    logic           sop;
    logic           eop;
  } tag_t;

  typedef struct packed {
    logic [DW-1:0] data;
    tag_t          tag;
  } word_t;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_RELEASE} state_t;

  state_t            state_q;
  state_t            next_state;
  logic              armed_q;
  logic [CHW-1:0]    ch_cnt_q;
  logic [RD_LAT-1:0] tag_v_q;
  tag_t              tag_q [RD_LAT];
  logic [DEPTH-1:0]  fifo_v_q;
  logic [DEPTH-1:0]  fifo_v_n;
  word_t             fifo_q [DEPTH];
  word_t             fifo_n [DEPTH];
  logic              eop_seen_q;

  logic [2:0]        occ_c;
  logic [2:0]        infl_c;
  logic              issue_c;
  logic              last_c;
  logic              pop_c;
  logic              push_c;
  logic              credit_c;
  logic [1:0]        wr_idx_c;
  logic [DW-1:0]     ch_word [NCH];
  word_t             push_word_c;
  tag_t              issue_tag_c;

  // FIFO head is the output register set
  assign out_valid = fifo_v_q[0];
  assign out_data  = fifo_q[0].data;
  assign out_ch    = fifo_q[0].tag.ch;
  assign out_bin   = fifo_q[0].tag.bin;
  assign out_sop   = fifo_q[0].tag.sop;
  assign out_eop   = fifo_q[0].tag.eop;

  // Occupancy, reads in flight and credit (a slot freed by this cycle's pop is reusable)
  always_comb begin
    occ_c  = '0;
    infl_c = '0;
    for (int i = 0; i < DEPTH; i++) occ_c = occ_c + 3'(fifo_v_q[i]);
    for (int i = 0; i < RD_LAT; i++) infl_c = infl_c + 3'(tag_v_q[i]);
    pop_c    = fifo_v_q[0] & out_ready;
    push_c   = tag_v_q[RD_LAT-1];
    credit_c = (4'(occ_c) + 4'(infl_c) - 4'(pop_c)) < 4'(DEPTH);
  end

  // Select the returning channel's word for the tag leaving the pipeline
  always_comb begin
    for (int k = 0; k < NCH; k++) ch_word[k] = ch_q[DW*k +: DW];
    push_word_c = '{data: ch_word[tag_q[RD_LAT-1].ch], tag: tag_q[RD_LAT-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= next_state;
  end

  always_comb begin
    next_state = state_q;
    case (state_q)
      S_IDLE:    if (armed_q && (&ch_ready)) next_state = S_READ;
      S_READ:    if (issue_c && last_c) next_state = S_DRAIN;
      S_DRAIN:   if (!fifo_v_q[0] && (infl_c == '0) && eop_seen_q) next_state = S_RELEASE;
      S_RELEASE: if (ch_ready == '0) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    issue_c     = 1'b0;
    last_c      = (ch_cnt_q == CHW'(NCH - 1)) && (rd_addr_fft == BW'(LAST));
    issue_tag_c = '{ch:  ch_cnt_q,
                    bin: rd_addr_fft,
                    sop: (ch_cnt_q == '0) && (rd_addr_fft == '0),
                    eop: last_c};
    if (state_q == S_READ) issue_c = credit_c;
  end

  // Shift-register FIFO: pop shifts toward the head, push fills the first free slot
  always_comb begin
    fifo_v_n = fifo_v_q;
    for (int i = 0; i < DEPTH; i++) fifo_n[i] = fifo_q[i];
    if (pop_c) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        fifo_v_n[i] = fifo_v_q[i+1];
        fifo_n[i]   = fifo_q[i+1];
      end
      fifo_v_n[DEPTH-1] = 1'b0;
    end
    wr_idx_c = 2'(occ_c - 3'(pop_c));
    if (push_c) begin
      fifo_v_n[wr_idx_c] = 1'b1;
      fifo_n[wr_idx_c]   = push_word_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q     <= 1'b0;
      ch_go       <= 1'b0;
      busy        <= 1'b0;
      rd_addr_fft <= '0;
      ch_cnt_q    <= '0;
      tag_v_q     <= '0;
      fifo_v_q    <= '0;
      eop_seen_q  <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      // first edge after release only arms the FSM
      armed_q <= 1'b1;
      ch_go   <= (next_state == S_RELEASE);
      busy    <= (next_state != S_IDLE);
      if (issue_c) begin
        if (rd_addr_fft == BW'(LAST)) begin
          rd_addr_fft <= '0;
          ch_cnt_q    <= (ch_cnt_q == CHW'(NCH - 1)) ? '0 : ch_cnt_q + CHW'(1);
        end else begin
          rd_addr_fft <= rd_addr_fft + BW'(1);
        end
      end
      tag_v_q[0] <= issue_c;
      tag_q[0]   <= issue_tag_c;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
      fifo_v_q <= fifo_v_n;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_n[i];
      if (state_q == S_IDLE)                  eop_seen_q <= 1'b0;
      else if (pop_c && fifo_q[0].tag.eop)    eop_seen_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_readout_sched.sv
// Scoreboard bench for fft_readout_sched: expected frames queued at frame start, monitor pops on each transfer.
`timescale 1ns/1ps
module tb_fft_readout_sched;

  localparam int NCH    = 4;
  localparam int NPTS   = 1024;
  localparam int RD_LAT = 2;
`ifdef FFT_SCHED_HALF_SPECTRUM_EN
  localparam int LAST   = NPTS / 2;
`else
  localparam int LAST   = NPTS - 1;
`endif
  localparam int TOTAL  = NCH * (LAST + 1);

  typedef struct packed {
    logic [27:0] data;
    logic [1:0]  ch;
    logic [9:0]  bin;
    logic        sop;
    logic        eop;
  } word_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    ch_ready = '0;
  logic [28*NCH-1:0] ch_q;
  logic [9:0]        rd_addr_fft;
  logic              ch_go;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [27:0]       out_data;
  logic [1:0]        out_ch;
  logic [9:0]        out_bin;
  logic              out_sop;
  logic              out_eop;
  logic              busy;

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];
  int    pops = 0;
  int    cyc = 0;
  int    rise_cyc = 0;
  int    sop_cyc = 0;
  int    eop_cyc = 0;
  int    base = 0;
  bit    rnd_mode = 1'b0;
  logic [9:0] addr_pipe [RD_LAT];

  fft_readout_sched #(.NCH(NCH), .NPTS(NPTS), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ch_ready(ch_ready), .ch_q(ch_q),
    .rd_addr_fft(rd_addr_fft), .ch_go(ch_go), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_bin(out_bin), .out_sop(out_sop), .out_eop(out_eop), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM content: low 12 bits are (ch<<10)|bin, upper bits a per-channel hash
  function automatic logic [27:0] ram_word(input int ch, input int bin);
    logic [15:0] h;
    h = 16'((ch * 40503 + bin * 7919) ^ 23130);
    return {h, 2'(ch), 10'(bin)};
  endfunction

  // Channel RAMs with RD_LAT cycles of read latency from the presented address
  always @(posedge clk) begin
    addr_pipe[0] <= rd_addr_fft;
    for (int i = 1; i < RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end

  always_comb begin
    ch_q = '0;
    for (int k = 0; k < NCH; k++) ch_q[28*k +: 28] = ram_word(k, int'(addr_pipe[RD_LAT-1]));
  end

  always @(posedge clk) begin
    #1;
    out_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Monitor: ordered scoreboard compare plus stall stability
  always @(negedge clk) begin : monitor
    word_t got;
    word_t want;
    word_t held;
    bit    stall_q;
    bit    prev_busy;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      stall_q   = 1'b0;
      prev_busy = 1'b0;
    end else begin
      got = '{data: out_data, ch: out_ch, bin: out_bin, sop: out_sop, eop: out_eop};
      if (busy && !prev_busy) rise_cyc = cyc;
      prev_busy = busy;
      if (stall_q) begin
        checks++;
        if (!out_valid || got != held) begin
          errors++;
          $display("FAIL stall_hold: valid=%0b word=%h, required valid=1 word=%h", out_valid, got, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        pops++;
        if (got.sop) sop_cyc = cyc;
        if (got.eop) eop_cyc = cyc;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected: got %h, required no transfer", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL word: got ch%0d bin%0d data %h sop%0b eop%0b, required ch%0d bin%0d data %h sop%0b eop%0b",
                     got.ch, got.bin, got.data, got.sop, got.eop,
                     want.ch, want.bin, want.data, want.sop, want.eop);
          end
        end
      end
      stall_q = out_valid && !out_ready;
      held    = got;
    end
  end

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic push_frame();
    for (int c = 0; c < NCH; c++) begin
      for (int b = 0; b <= LAST; b++) begin
        word_t w;
        w.data = ram_word(c, b);
        w.ch   = 2'(c);
        w.bin  = 10'(b);
        w.sop  = (c == 0) && (b == 0);
        w.eop  = (c == NCH - 1) && (b == LAST);
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sop"}, out_sop, 0);
    chk({tag, "_out_eop"}, out_eop, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_ch"}, out_ch, 0);
    chk({tag, "_out_bin"}, out_bin, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ch_go"}, ch_go, 0);
    chk({tag, "_rd_addr"}, rd_addr_fft, 0);
  endtask

  task automatic wait_empty(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, exp_q.size(), 0);
  endtask

  task automatic wait_pops(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (pops < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pops < target) begin
      errors++;
      $display("FAIL %s_timeout: got %0d transfers, required %0d", name, pops, target);
    end
  endtask

  task automatic wait_go(input int budget, input string name);
    int n;
    n = 0;
    while (!ch_go && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ch_go"}, ch_go, 1);
  endtask

  // Release handshake: ch_go held while ch_ready stays high, then drop ch_ready
  task automatic finish_frame(input string name);
    wait_go(200, name);
    repeat (3) begin
      @(negedge clk);
      chk({name, "_go_high"}, ch_go, 1);
      chk({name, "_busy_high"}, busy, 1);
    end
    @(posedge clk);
    #1;
    ch_ready = '0;
    @(negedge clk);
    chk({name, "_go_hold"}, ch_go, 1);
    @(negedge clk);
    chk({name, "_go_low"}, ch_go, 0);
    chk({name, "_idle"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Full-rate frame: ordering, latency, gapless stream
    rnd_mode = 1'b0;
    @(posedge clk);
    #1;
    ch_ready = '1;
    push_frame();
    base = pops;
    wait_empty(3 * TOTAL, "frame_a");
    chk("frame_a_count", pops - base, TOTAL);
    chk("frame_a_latency", sop_cyc - rise_cyc, RD_LAT + 1);
    chk("frame_a_gapless", eop_cyc - sop_cyc, TOTAL - 1);
    finish_frame("frame_a");

    // Partial readiness holds IDLE, then random backpressure frame
    ch_ready = 4'b0111;
    repeat (500) begin
      @(negedge clk);
      chk("partial_idle", {busy, out_valid, ch_go, rd_addr_fft}, 0);
    end
    rnd_mode = 1'b1;
    @(posedge clk);
    #1;
    ch_ready = '1;
    push_frame();
    base = pops;
    @(negedge clk);
    chk("start_not_early", busy, 0);
    @(negedge clk);
    chk("start_next_cycle", busy, 1);
    wait_empty(8 * TOTAL, "frame_b");
    chk("frame_b_count", pops - base, TOTAL);
    rnd_mode = 1'b0;
    finish_frame("frame_b");

    // Reset mid-frame at ch1 bin 300, then a fresh frame
    @(posedge clk);
    #1;
    ch_ready = '1;
    push_frame();
    base = pops;
    wait_pops(base + LAST + 1 + 301, 4 * TOTAL, "reach_ch1_bin300");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    push_frame();
    base = pops;
    @(posedge clk);
    #1;
    chk("release_first_edge_idle", busy, 0);
    wait_empty(3 * TOTAL, "frame_c");
    chk("frame_c_count", pops - base, TOTAL);
    finish_frame("frame_c");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
